// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination lock.
// Digit slices are numbered MSB-first, digit 0 keyed first.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    OPEN,
    LOCKOUT
  } lock_state_t;

  localparam int unsigned MAX_CODE_W  = 64;
  localparam int unsigned MAX_DIGIT_W = 16;

  function automatic logic [MAX_DIGIT_W-1:0] code_digit(
    input logic [MAX_CODE_W-1:0] code,
    input int unsigned           idx,
    input int unsigned           dw,
    input int unsigned           nd
  );
    logic [MAX_CODE_W-1:0]  sh;
    logic [MAX_DIGIT_W-1:0] mask;
    sh   = code >> ((nd - 1 - idx) * dw);
    mask = (MAX_DIGIT_W'(1) << dw) - MAX_DIGIT_W'(1);
    return sh[MAX_DIGIT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/combo_lock_fsm_key_press_edge.sv
// Rising-edge detector for a synchronised key level.
// Resets high so a key held through reset is not a press.
module key_press_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (reset) key_q <= 1'b1;
    else       key_q <= key;
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/combo_lock_fsm.sv
// Multi-digit combination lock with failed-attempt lockout.
// Digits are committed one per enter press, MSB slice first.
module combo_lock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 2,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE = 8'h26,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int CW = $clog2(NUM_DIGITS+1),
  localparam int FW = $clog2(MAX_TRIES+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  input  logic               clear,
  input  logic               relock,
  output logic               unlocked,
  output logic               locked_out,
  output logic               error,
  output logic [CW-1:0]      digit_count,
  output logic [FW-1:0]      fail_count
);

  import combo_lock_pkg::*;

  localparam int TW =
    (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS-1);

  lock_state_t   state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;
  logic          press;
  logic          mis_now;
  logic [31:0]   fail_next;
  logic [DIGIT_W-1:0] exp_digit;

  key_press_edge u_enter (
    .clk   (clk),
    .reset (reset),
    .key   (enter),
    .press (press)
  );

  assign exp_digit = DIGIT_W'(code_digit(
    MAX_CODE_W'(CODE), 32'(dcnt_q), DIGIT_W, NUM_DIGITS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
      tmr_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
      tmr_q   <= tmr_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    fcnt_d    = fcnt_q;
    tmr_d     = tmr_q;
    mis_d     = mis_q;
    err_d     = 1'b0;
    mis_now   = mis_q | (digit_in != exp_digit);
    fail_next = 32'(fcnt_q) + 32'd1;
    unique case (state_q)
      ENTRY: begin
        if (clear) begin
          dcnt_d = '0;
          mis_d  = 1'b0;
        end else if (press) begin
          if (dcnt_q != LAST) begin
            dcnt_d = dcnt_q + CW'(1);
            mis_d  = mis_now;
          end else if (!mis_now) begin
            state_d = OPEN;
            dcnt_d  = '0;
            fcnt_d  = '0;
            mis_d   = 1'b0;
          end else begin
            err_d  = 1'b1;
            dcnt_d = '0;
            mis_d  = 1'b0;
            // saturate at MAX_TRIES; reaching it starts the lockout
            if (fail_next >= 32'(MAX_TRIES)) begin
              fcnt_d  = FW'(MAX_TRIES);
              state_d = LOCKOUT;
              tmr_d   = TW'(LOCKOUT_CYCLES-1);
            end else begin
              fcnt_d = fcnt_q + FW'(1);
            end
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_d = ENTRY;
          dcnt_d  = '0;
          fcnt_d  = '0;
          mis_d   = 1'b0;
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = ENTRY;
          fcnt_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  assign unlocked    = (state_q == OPEN);
  assign locked_out  = (state_q == LOCKOUT);
  assign error       = err_q;
  assign digit_count = dcnt_q;
  assign fail_count  = fcnt_q;

endmodule

// File: doc/combo_lock_fsm.md
Name: combo_lock_fsm

Overview:
Sequential, parametrised successor to the board's fixed two-digit switch-code detector.
- Instead of comparing one static switch pattern, the user keys in a NUM_DIGITS-long code one digit at a time. Each digit is set on digit_in and committed with an enter press.
- The block unlocks on a full correct sequence. It counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures.
- Sits between the synchronised switch/KEY inputs and the LEDR/HEX display logic of the DE1_SoC top level.

Parameters:
- DIGIT_W, 4: bits per code digit.
- NUM_DIGITS, 2: digits per code (>=1).
- CODE, 8'h26: NUM_DIGITS*DIGIT_W-bit code; digit 0 is the most-significant DIGIT_W slice and is entered first.
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 16: clock cycles spent in lockout (>=1); the board instance overrides this to 50_000_000.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- digit_in, input, DIGIT_W: digit currently presented, already synchronised.
- enter, input, 1: commit level, active-high, already synchronised; the block edge-detects it internally.
- clear, input, 1: abort the partial entry (level).
- relock, input, 1: leave the unlocked state (level).
- unlocked, output, 1: high while in OPEN.
- locked_out, output, 1: high while in LOCKOUT.
- error, output, 1: single-cycle pulse on a failed attempt.
- digit_count, output, $clog2(NUM_DIGITS+1): digits accepted in the current attempt.
- fail_count, output, $clog2(MAX_TRIES+1): consecutive failed attempts.

Behaviour:
- Reset values: state=ENTRY; unlocked, locked_out, error, digit_count and fail_count all 0; mismatch flag 0; lockout timer 0; enter_q=1.
  - enter_q=1 ensures a key held through reset is not taken as a press.
- Press definition: press = enter & ~enter_q; enter_q <= enter every cycle.
  - A held enter produces exactly one press.
  - Effects of a press are visible on outputs the following cycle (1-cycle latency).
- ENTRY, on a press:
  - Compare digit_in with CODE slice [digit_count]; mismatch |= (digit_in != slice).
  - If digit_count < NUM_DIGITS-1: digit_count++.
  - Final digit, no mismatch including the current one: go to OPEN; digit_count=0; fail_count=0.
  - Final digit, any mismatch: error pulses for 1 cycle; digit_count=0; mismatch=0; fail_count++.
    - If the new fail_count == MAX_TRIES: go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
    - Otherwise stay in ENTRY.
- ENTRY, on clear: digit_count=0 and mismatch=0. No failure is counted and error does not pulse.
- clear and a press in the same cycle: clear wins and the digit is discarded.
- OPEN:
  - unlocked=1. Presses are ignored.
  - relock=1 goes to ENTRY with all counters 0.
  - relock and a press in the same cycle: go to ENTRY; the press is consumed and not recorded as a digit.
- LOCKOUT:
  - locked_out=1. Presses, clear and relock are all ignored.
  - The timer decrements each cycle. On the cycle the timer reads 0, go to ENTRY with fail_count=0.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- Counter rules:
  - fail_count saturates at MAX_TRIES and never wraps.
  - digit_count never exceeds NUM_DIGITS-1 while in ENTRY.
- Reset asserted in any state, mid-entry or mid-lockout: all reset values are applied on the next clock edge.
- NUM_DIGITS=1: every press is the final digit.
- Comparison is exact equality on DIGIT_W bits. There is no BCD range check; digit values above 9 are simply mismatches against a BCD code.

Decomposition:
- Package combo_lock_pkg holds:
  - typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} lock_state_t;
  - helper function code_digit(code, idx), which returns slice idx, MSB-first.
- One sub-module, key_press_edge: the enter_q register and press pulse, with reset value 1.
  - It is reused later for the other KEY inputs.

Test Plan:
- Correct code: after reset, enter digits 2 then 6 with 1-cycle enter pulses -> digit_count goes 1 then 0; unlocked=1 one cycle after the second press; error never pulses.
- Wrong code: enter 2 then 7 -> error pulses exactly 1 cycle; fail_count=1; unlocked stays 0. Enter 2,6 -> unlocked=1 and fail_count=0.
- Lockout: three wrong attempts (3,6 / 2,5 / 9,9) -> locked_out=1 for exactly 16 cycles.
  - Presses of 2,6 during lockout are ignored: unlocked=0 and digit_count=0 throughout.
  - Lockout then exits to ENTRY with fail_count=0.
- Clear and hold: enter 2, assert clear together with a press of 6 -> digit_count=0 and no error.
  - Hold enter high for 20 cycles with digit_in=2 -> only one digit is accepted.
- Relock and reset: in OPEN, assert relock with a simultaneous press -> ENTRY, digit_count=0.
  - Mid-lockout, pulse reset -> next cycle locked_out=0, fail_count=0, state ENTRY.
- Parameter sweep: NUM_DIGITS=3, CODE=12'h469, MAX_TRIES=1 -> 4,6,9 unlocks; any single wrong attempt enters LOCKOUT immediately.
